bus_timer_array: RTL and testbench

Multi-channel, bus-mapped down-counting timer peripheral for the 8-bit processor bus; successor to the single-channel system timer. Provides up to 4 independent channels, each with configurable reload, one-shot/periodic mode and interrupt enable, sharing one prescaler. All channels share one interrupt line using the bus raise/acknowledge handshake. Instantiated in the system top alongside RAM, ROM and the seven-segment driver, on one interrupt slot.

---
 rtl/bus_timer_pkg.sv | 42 ++++
 rtl/bus_timer_channel.sv | 148 ++++++++++++++
 rtl/bus_timer_array.sv | 123 ++++++++++++
 tb/tb_bus_timer_array.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared constants, register map and address decode for the bus_timer_array
// peripheral and its per-channel sub-module.
package bus_timer_pkg;

  // Register offsets within one channel's 4-byte window
  localparam int unsigned OFS_CTRL      = 0;
  localparam int unsigned OFS_RELOAD_LO = 1;
  localparam int unsigned OFS_RELOAD_HI = 2;
  localparam int unsigned OFS_STATUS    = 3;

  // CTRL / STATUS bit positions
  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_PERIODIC  = 1;
  localparam int unsigned CTRL_IRQ_EN    = 2;
  localparam int unsigned STATUS_EXPIRED = 0;

  // Legal configuration limits
  localparam int unsigned CHANNELS_MIN   = 1;
  localparam int unsigned CHANNELS_MAX   = 4;
  localparam int unsigned COUNT_W_NARROW = 8;
  localparam int unsigned COUNT_W_WIDE   = 16;

  typedef struct packed {
    logic       hit;
    logic [1:0] chan;
    logic [1:0] ofs;
  } bus_dec_t;

  // Offset from base wraps modulo 256, so addresses below base never hit.
  function automatic bus_dec_t decode_addr(input logic [7:0] addr,
                                           input logic [7:0] base,
                                           input int unsigned channels);
    logic [7:0] rel;
    bus_dec_t   d;
    rel    = addr - base;
    d.hit  = (32'(rel) < (channels * 4));
    d.chan = rel[3:2];
    d.ofs  = rel[1:0];
    return d;
  endfunction

endpackage

// File: rtl/bus_timer_channel.sv
// One down-counting timer channel: CTRL, RELOAD, count, EXPIRED flag and
// (with BUS_TIMER_COUNT_READ_EN) a high-byte shadow for atomic count reads.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_tick           shared prescaler tick
//   i_wr_en          bus write addressed to this channel
//   i_rd_en          bus read addressed to this channel (BUS_TIMER_COUNT_READ_EN only)
//   i_ofs, i_wdata   register offset and write data
//   o_expire_c       expiry event this cycle
//   o_irq_en         CTRL.IRQ_EN
//   o_rdata_c        read data for i_ofs
module bus_timer_channel
  import bus_timer_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_wr_en,
`ifdef BUS_TIMER_COUNT_READ_EN
  input  logic       i_rd_en,
`endif
  input  logic [1:0] i_ofs,
  input  logic [7:0] i_wdata,
  output logic       o_expire_c,
  output logic       o_irq_en,
  output logic [7:0] o_rdata_c
);

  logic               r_en;
  logic               r_periodic;
  logic               r_irq_en;
  logic               r_expired;
  logic [7:0]         r_reload_lo;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_reload;
  logic               w_ctrl_wr;
  logic               w_lo_wr;
  logic               w_hi_wr;
  logic               w_st_wr;
  logic               w_count_zero;
  logic               w_enable_rise;

  assign w_ctrl_wr     = i_wr_en && (i_ofs == 2'(OFS_CTRL));
  assign w_lo_wr       = i_wr_en && (i_ofs == 2'(OFS_RELOAD_LO));
  assign w_hi_wr       = i_wr_en && (i_ofs == 2'(OFS_RELOAD_HI));
  assign w_st_wr       = i_wr_en && (i_ofs == 2'(OFS_STATUS));
  assign w_count_zero  = (r_count == '0);
  assign w_enable_rise = w_ctrl_wr && !r_en && i_wdata[CTRL_EN];
  assign o_expire_c    = i_tick && r_en && w_count_zero;
  assign o_irq_en      = r_irq_en;

  // Reload high byte exists only for wide counters
  if (COUNT_W > 8) begin : g_reload_hi
    logic [COUNT_W-9:0] r_reload_hi;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_reload_hi <= '0;
      end else if (w_hi_wr) begin
        r_reload_hi <= i_wdata[COUNT_W-9:0];
      end
    end
    assign w_reload = {r_reload_hi, r_reload_lo};
  end else begin : g_reload_narrow
    assign w_reload = COUNT_W'(r_reload_lo);
  end

  // CTRL: a bus write always wins over the one-shot hardware clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en       <= 1'b0;
      r_periodic <= 1'b0;
      r_irq_en   <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en       <= i_wdata[CTRL_EN];
      r_periodic <= i_wdata[CTRL_PERIODIC];
      r_irq_en   <= i_wdata[CTRL_IRQ_EN];
    end else if (o_expire_c && !r_periodic) begin
      r_en       <= 1'b0;
    end
  end

  // Reload low byte
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_reload_lo <= '0;
    end else if (w_lo_wr) begin
      r_reload_lo <= i_wdata;
    end
  end

  // Counter: load on enable rising, otherwise count down on tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (w_enable_rise) begin
      r_count <= w_reload;
    end else if (i_tick && r_en) begin
      if (!w_count_zero) begin
        r_count <= r_count - COUNT_W'(1);
      end else if (r_periodic) begin
        r_count <= w_reload;
      end
    end
  end

  // EXPIRED: a new expiry beats a simultaneous write-1-to-clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_expired <= 1'b0;
    end else if (o_expire_c) begin
      r_expired <= 1'b1;
    end else if (w_st_wr && i_wdata[STATUS_EXPIRED]) begin
      r_expired <= 1'b0;
    end
  end

`ifdef BUS_TIMER_COUNT_READ_EN
  // High byte captured when the low byte is read, so lo-then-hi is coherent
  logic [7:0] r_shadow;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else if (i_rd_en && (i_ofs == 2'(OFS_RELOAD_LO))) begin
      r_shadow <= 8'(r_count >> 8);
    end
  end
`endif

  // Read data mux
  always_comb begin
    o_rdata_c = '0;
    case (i_ofs)
      2'(OFS_CTRL):      o_rdata_c = {5'd0, r_irq_en, r_periodic, r_en};
`ifdef BUS_TIMER_COUNT_READ_EN
      2'(OFS_RELOAD_LO): o_rdata_c = 8'(r_count);
      2'(OFS_RELOAD_HI): o_rdata_c = r_shadow;
`else
      2'(OFS_RELOAD_LO): o_rdata_c = 8'(w_reload);
      2'(OFS_RELOAD_HI): o_rdata_c = 8'(w_reload >> 8);
`endif
      2'(OFS_STATUS):    o_rdata_c = {7'd0, r_expired};
      default:           o_rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/bus_timer_array.sv
// Multi-channel bus-mapped down-counting timer with a shared prescaler and a
// single raise/acknowledge interrupt line.
// Optional feature macro: BUS_TIMER_COUNT_READ_EN (offsets +1/+2 read the live
// count through a per-channel shadow instead of RELOAD).
// Ports:
//   CLK                   system clock, rising edge
//   RESET                 asynchronous active-low reset
//   BUS_DATA              shared 8-bit data bus, driven only for a read
//   BUS_ADDR, BUS_WE      bus address and write strobe
//   BUS_INTERRUPT_RAISE   interrupt request, held until acknowledged
//   BUS_INTERRUPT_ACK     single-cycle acknowledge
module bus_timer_array
  import bus_timer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'hF0,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned TICK_DIV  = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
      (COUNT_W != COUNT_W_NARROW && COUNT_W != COUNT_W_WIDE) ||
      TICK_DIV < 2) begin : g_bad_cfg
    $error("bus_timer_array: illegal parameter combination");
  end

  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;
  bus_dec_t           w_dec;
  logic               w_wr_hit;
  logic               w_rd_hit;
  logic [CHANNELS-1:0] w_expire;
  logic [CHANNELS-1:0] w_irq_en;
  logic [7:0]         w_rdata [CHANNELS];
  logic [7:0]         w_rdata_sel;
  logic               r_raise;
  logic               r_rd_en;
  logic [7:0]         r_rd_data;

  // Free-running prescaler, one-cycle tick at the terminal value
  assign w_tick = (r_presc == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Address decode
  assign w_dec    = decode_addr(BUS_ADDR, BASE_ADDR, CHANNELS);
  assign w_wr_hit = BUS_WE && w_dec.hit;
  assign w_rd_hit = !BUS_WE && w_dec.hit;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    bus_timer_channel #(
      .COUNT_W (COUNT_W)
    ) u_chan (
      .i_clk      (CLK),
      .i_rst_n    (RESET),
      .i_tick     (w_tick),
      .i_wr_en    (w_wr_hit && (w_dec.chan == 2'(g))),
`ifdef BUS_TIMER_COUNT_READ_EN
      .i_rd_en    (w_rd_hit && (w_dec.chan == 2'(g))),
`endif
      .i_ofs      (w_dec.ofs),
      .i_wdata    (BUS_DATA),
      .o_expire_c (w_expire[g]),
      .o_irq_en   (w_irq_en[g]),
      .o_rdata_c  (w_rdata[g])
    );
  end

  // Select the addressed channel's read data
  always_comb begin
    w_rdata_sel = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_dec.chan == 2'(c)) begin
        w_rdata_sel = w_rdata[c];
      end
    end
  end

  // Read data is driven for exactly the cycle after the address is sampled
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_en   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_en   <= w_rd_hit;
      r_rd_data <= w_rdata_sel;
    end
  end

  assign BUS_DATA = r_rd_en ? r_rd_data : 8'hzz;

  // Interrupt: a new qualifying expiry beats a simultaneous acknowledge
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_raise <= 1'b0;
    end else if (|(w_expire & w_irq_en)) begin
      r_raise <= 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      r_raise <= 1'b0;
    end
  end

  assign BUS_INTERRUPT_RAISE = r_raise;

endmodule

// File: tb/tb_bus_timer_array.sv
// Scoreboard bench for bus_timer_array: the driver pushes expected bus/raise
// values with the cycle they are due; a negedge monitor pops and compares.
module tb_bus_timer_array;

`ifdef BUS_TIMER_COUNT_READ_EN
  localparam bit CNT_RD = 1'b1;
`else
  localparam bit CNT_RD = 1'b0;
`endif
  localparam logic [7:0] IDLE_ADDR = 8'h00;

  typedef struct {
    int         due;
    bit         is_raise;
    logic [7:0] exp;
    string      name;
  } chk_t;

  logic       clk;
  logic       rst_n;
  logic       we;
  logic       ack;
  logic       drv;
  logic [7:0] addr;
  logic [7:0] dat;
  logic       raise;
  tri1  [7:0] bus_data;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  chk_t q[$];

  assign bus_data = drv ? dat : 8'hzz;

  bus_timer_array #(
    .BASE_ADDR (8'hF0),
    .CHANNELS  (4),
    .COUNT_W   (16),
    .TICK_DIV  (4)
  ) dut (
    .CLK                 (clk),
    .RESET               (rst_n),
    .BUS_DATA            (bus_data),
    .BUS_ADDR            (addr),
    .BUS_WE              (we),
    .BUS_INTERRUPT_RAISE (raise),
    .BUS_INTERRUPT_ACK   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation at its due negedge
  always @(negedge clk) begin
    chk_t       it;
    logic [7:0] act;
    while (q.size() > 0 && q[0].due <= cyc) begin
      it  = q.pop_front();
      act = it.is_raise ? {7'd0, raise} : bus_data;
      checks++;
      if (it.due != cyc) begin
        failures++;
        $display("FAIL %s: check missed, due=%0d now=%0d", it.name, it.due, cyc);
      end else if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got=%02h want=%02h cyc=%0d", it.name, act, it.exp, cyc);
      end
    end
  end

  task automatic goto(input int c);
    if (c < cyc) begin
      failures++;
      $display("FAIL sequence: target cycle %0d already passed (now %0d)", c, cyc);
    end
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr(input int c, input logic [7:0] a, input logic [7:0] d);
    goto(c);
    addr = a; we = 1'b1; dat = d; drv = 1'b1;
    @(negedge clk);
    addr = IDLE_ADDR; we = 1'b0; drv = 1'b0;
  endtask

  task automatic rd(input int c, input logic [7:0] a, input logic [7:0] e, input string n);
    goto(c);
    q.push_back('{due: c + 1, is_raise: 1'b0, exp: e, name: n});
    addr = a; we = 1'b0;
    @(negedge clk);
    addr = IDLE_ADDR;
  endtask

  task automatic exp_bus(input int d, input logic [7:0] e, input string n);
    q.push_back('{due: d, is_raise: 1'b0, exp: e, name: n});
  endtask

  task automatic exp_raise(input int d, input logic e, input string n);
    q.push_back('{due: d, is_raise: 1'b1, exp: {7'd0, e}, name: n});
  endtask

  task automatic do_ack(input int c);
    goto(c);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    #20000;
    failures++;
    $display("FAIL watchdog: bench did not complete");
    summary();
    $finish;
  end

  // Ticks land on edges 4k after each reset release (TICK_DIV=4).
  initial begin
    rst_n = 1'b0; we = 1'b0; ack = 1'b0; drv = 1'b0; dat = '0; addr = IDLE_ADDR;
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Reset values and out-of-range read
    rd(1, 8'hF0, 8'h00, "rst_ch0_ctrl");
    rd(2, 8'hF1, 8'h00, "rst_ch0_rl_lo");
    rd(3, 8'hF2, 8'h00, "rst_ch0_rl_hi");
    rd(4, 8'hF3, 8'h00, "rst_ch0_status");
    rd(5, 8'hFC, 8'h00, "rst_ch3_ctrl");
    exp_raise(7, 1'b0, "rst_raise");
    rd(6, 8'hEF, 8'hFF, "below_base_hiz");

    // ch1 one-shot, no IRQ: reload 2 loaded at edge 13, expires at edge 24
    wr(10, 8'hF5, 8'h02);
    wr(12, 8'hF4, 8'h01);
    rd(23, 8'hF7, 8'h00, "ch1_status_pre");
    rd(24, 8'hF7, 8'h01, "ch1_status_expired");
    rd(25, 8'hF4, 8'h00, "ch1_ctrl_cleared");
    exp_raise(27, 1'b0, "ch1_no_raise");
    exp_raise(29, 1'b0, "ch1_no_raise_late");

    // ch0 periodic with IRQ: reload 3 loaded at edge 33, expiries at 48, 64, 80, 96
    wr(30, 8'hF1, 8'h03);
    wr(32, 8'hF0, 8'h07);
    exp_raise(47, 1'b0, "ch0_raise_pre");
    exp_raise(48, 1'b1, "ch0_raise_expiry");
    rd(48, 8'hF3, 8'h01, "ch0_status_expired");
    exp_raise(50, 1'b1, "ch0_raise_held");
    exp_raise(51, 1'b0, "ch0_ack_drops");
    do_ack(50);
    rd(52, 8'hF3, 8'h01, "ch0_status_after_ack");
    exp_raise(63, 1'b0, "ch0_raise_pre2");
    exp_raise(64, 1'b1, "ch0_raise_period");
    exp_raise(80, 1'b1, "ack_vs_expiry");
    do_ack(79);
    exp_raise(83, 1'b0, "ch0_ack_drops2");
    do_ack(82);
    wr(95, 8'hF3, 8'h01);
    rd(96, 8'hF3, 8'h01, "clear_vs_expiry");
    wr(98, 8'hF3, 8'h01);
    rd(99, 8'hF3, 8'h00, "status_clear");
    wr(101, 8'hF0, 8'h00);
    rd(103, 8'hF0, 8'h00, "ch0_ctrl_off");

    // ch2 reload 16'h1234: read data lasts exactly one cycle
    wr(105, 8'hF9, 8'h34);
    wr(107, 8'hFA, 8'h12);
    rd(109, 8'hF9, CNT_RD ? 8'h00 : 8'h34, "ch2_rd_lo");
    exp_bus(111, 8'hFF, "rd_released");
    rd(111, 8'hFA, CNT_RD ? 8'h00 : 8'h12, "ch2_rd_hi");

    // ch3 reload 16'h0101: count 0100 at edge 120, 00FF at edge 124
    wr(114, 8'hFD, 8'h01);
    wr(116, 8'hFE, 8'h01);
    wr(118, 8'hFC, 8'h01);
    rd(121, 8'hFD, CNT_RD ? 8'h00 : 8'h01, "ch3_cnt_lo");
    rd(125, 8'hFE, 8'h01, "ch3_cnt_hi_shadow");
    rd(126, 8'hFD, CNT_RD ? 8'hFF : 8'h01, "ch3_cnt_lo_after");

    // Asynchronous reset while RAISE is pending
    exp_raise(128, 1'b1, "raise_before_reset");
    exp_raise(130, 1'b0, "raise_async_reset");
    goto(129);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rd(130, 8'hF0, 8'hFF, "no_drive_in_reset");
    goto(132);
    #2 rst_n = 1'b1;
    rd(134, 8'hF0, 8'h00, "post_rst_ch0_ctrl");
    rd(135, 8'hF3, 8'h00, "post_rst_ch0_status");
    rd(136, 8'hF9, 8'h00, "post_rst_ch2_rl_lo");
    rd(137, 8'hFE, 8'h00, "post_rst_ch3_rl_hi");
    exp_raise(139, 1'b0, "post_rst_raise");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d checks never reached", q.size());
    end
    summary();
    $finish;
  end

endmodule
